id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/id_ctrl_decode.sv | 60 ++++++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, ALU_OP and control-bundle definitions for the ID/EX stage
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       ill_insn;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ctrl_decode.sv
// rtl/id_ctrl_decode.sv - combinational control decode of one 32-bit instruction word
module id_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rs2_used,
    output logic [9:0]  alu_ctrl
);

    logic [6:0] opcode;

    assign opcode = instruction[6:0];

    always_comb begin
        ctrl     = CTRL_NOP;
        rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.alu_op   = ALU_OP_FUNCT;
                rs2_used      = 1'b1;
            end
            OP_I_ALU: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_op   = ALU_OP_FUNCT;
            end
            OP_LOAD: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alu_op   = ALU_OP_ADD;
            end
            OP_STORE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.alu_op   = ALU_OP_ADD;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_op   = ALU_OP_BRANCH;
                rs2_used      = 1'b1;
            end
            default: ctrl.ill_insn = 1'b1;
        endcase
    end

    // Unused register fields read as x0 so downstream forwarding never matches garbage
    assign rs1      = instruction[19:15];
    assign rs2      = rs2_used ? instruction[24:20] : 5'd0;
    assign rd       = (ctrl.branch | ctrl.memwrite | ctrl.ill_insn) ? 5'd0 : instruction[11:7];
    assign alu_ctrl = {instruction[31:25], instruction[14:12]};

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with handshake, flush and load-use stall; ID_EX_PERF_EN adds stall/bubble counters
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
`ifdef ID_EX_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rdata1_in,
    input  logic [XLEN-1:0] rdata2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] rdata1_q,
    output logic [XLEN-1:0] rdata2_q,
    output logic [XLEN-1:0] imm_q,
    output logic [31:0]     instr_q,
    output logic [4:0]      rs1_q,
    output logic [4:0]      rs2_q,
    output logic [4:0]      rd_q,
    output logic [9:0]      alu_ctrl_q,
    output logic [1:0]      alu_op_q,
    output logic            alusrc_q,
    output logic            branch_q,
    output logic            memread_q,
    output logic            memwrite_q,
    output logic            memtoreg_q,
    output logic            regwrite_q,
    output logic            ill_insn_q,
    output logic            hazard_stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] bubble_cnt
`endif
);

    ctrl_t      dec_ctrl;
    ctrl_t      ctrl_q;
    logic [4:0] rs1_dec;
    logic [4:0] rs2_dec;
    logic [4:0] rd_dec;
    logic       rs2_used_dec;
    logic [9:0] alu_ctrl_dec;
    logic       load;

    id_ctrl_decode u_decode (
        .instruction (instruction),
        .ctrl        (dec_ctrl),
        .rs1         (rs1_dec),
        .rs2         (rs2_dec),
        .rd          (rd_dec),
        .rs2_used    (rs2_used_dec),
        .alu_ctrl    (alu_ctrl_dec)
    );

    assign hazard_stall = out_valid & ctrl_q.memread & (rd_q != 5'd0)
                        & ((rs1_dec == rd_q) | (rs2_used_dec & (rs2_dec == rd_q)));

    // Flush always consumes the presented word so decode can move on to the redirect target
    assign in_ready = flush | (~hazard_stall & (~out_valid | out_ready));
    assign load     = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            pc_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_ctrl_q <= '0;
            ctrl_q     <= CTRL_NOP;
        end else if (load) begin
            out_valid  <= 1'b1;
            pc_q       <= pc_in;
            rdata1_q   <= rdata1_in;
            rdata2_q   <= rdata2_in;
            imm_q      <= imm_in;
            instr_q    <= instruction;
            rs1_q      <= rs1_dec;
            rs2_q      <= rs2_dec;
            rd_q       <= rd_dec;
            alu_ctrl_q <= alu_ctrl_dec;
            ctrl_q     <= dec_ctrl;
        end else if (flush || (out_valid && out_ready)) begin
            // Bubble: payload stays, but side-effecting controls drop so an idle slot is harmless
            out_valid       <= 1'b0;
            ctrl_q.regwrite <= 1'b0;
            ctrl_q.memwrite <= 1'b0;
            ctrl_q.memread  <= 1'b0;
            ctrl_q.branch   <= 1'b0;
        end
    end

    assign alu_op_q   = ctrl_q.alu_op;
    assign alusrc_q   = ctrl_q.alusrc;
    assign branch_q   = ctrl_q.branch;
    assign memread_q  = ctrl_q.memread;
    assign memwrite_q = ctrl_q.memwrite;
    assign memtoreg_q = ctrl_q.memtoreg;
    assign regwrite_q = ctrl_q.regwrite;
    assign ill_insn_q = ctrl_q.ill_insn;

`ifdef ID_EX_PERF_EN
    logic bubble;

    assign bubble = out_valid & (flush | (out_ready & ~load));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (hazard_stall && in_valid && (stall_cnt != '1))
                stall_cnt <= stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
            if (bubble && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_in, rdata1_in, rdata2_in, imm_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_q, rdata1_q, rdata2_q, imm_q;
    logic [31:0]     instr_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [9:0]      alu_ctrl_q;
    logic [1:0]      alu_op_q;
    logic            alusrc_q, branch_q, memread_q, memwrite_q, memtoreg_q, regwrite_q, ill_insn_q;
    logic            hazard_stall;
`ifdef ID_EX_PERF_EN
    logic [31:0]     stall_cnt, bubble_cnt;
`endif

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .pc_in        (pc_in),
        .rdata1_in    (rdata1_in),
        .rdata2_in    (rdata2_in),
        .imm_in       (imm_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_q         (pc_q),
        .rdata1_q     (rdata1_q),
        .rdata2_q     (rdata2_q),
        .imm_q        (imm_q),
        .instr_q      (instr_q),
        .rs1_q        (rs1_q),
        .rs2_q        (rs2_q),
        .rd_q         (rd_q),
        .alu_ctrl_q   (alu_ctrl_q),
        .alu_op_q     (alu_op_q),
        .alusrc_q     (alusrc_q),
        .branch_q     (branch_q),
        .memread_q    (memread_q),
        .memwrite_q   (memwrite_q),
        .memtoreg_q   (memtoreg_q),
        .regwrite_q   (regwrite_q),
        .ill_insn_q   (ill_insn_q),
        .hazard_stall (hazard_stall)
`ifdef ID_EX_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] pc, r1, r2, imm;
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  alu_ctrl;
        logic [8:0]  ctl;
    } exp_t;

    // Reference decode: {alu_op, alusrc, branch, memread, memwrite, memtoreg, regwrite, ill}
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] imm);
        exp_t e;
        logic [1:0] aop;
        logic s, b, mr, mw, mt, rw, ill, use2, nord;
        {aop, s, b, mr, mw, mt, rw, ill, use2, nord} = '0;
        case (ins[6:0])
            7'h33:   begin rw = 1; aop = 2'b10; use2 = 1; end
            7'h13:   begin rw = 1; s = 1; aop = 2'b10; end
            7'h03:   begin rw = 1; s = 1; mr = 1; mt = 1; end
            7'h23:   begin s = 1; mw = 1; use2 = 1; nord = 1; end
            7'h63:   begin b = 1; aop = 2'b01; use2 = 1; nord = 1; end
            default: begin ill = 1; nord = 1; end
        endcase
        e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.instr = ins;
        e.rs1 = ins[19:15];
        e.rs2 = use2 ? ins[24:20] : 5'd0;
        e.rd  = nord ? 5'd0 : ins[11:7];
        e.alu_ctrl = {ins[31:25], ins[14:12]};
        e.ctl = {aop, s, b, mr, mw, mt, rw, ill};
        return e;
    endfunction

    exp_t sbq[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid && (out_ready || flush)) begin
                if (sbq.size() == 0) begin
                    check_eq("sb_underflow", sbq.size(), 1);
                end else begin
                    sb_e = sbq.pop_front();
                    if (!flush) begin
                        check_eq("sb_pc", pc_q, sb_e.pc);
                        check_eq("sb_rdata1", rdata1_q, sb_e.r1);
                        check_eq("sb_rdata2", rdata2_q, sb_e.r2);
                        check_eq("sb_imm", imm_q, sb_e.imm);
                        check_eq("sb_instr", instr_q, sb_e.instr);
                        check_eq("sb_rs1", rs1_q, sb_e.rs1);
                        check_eq("sb_rs2", rs2_q, sb_e.rs2);
                        check_eq("sb_rd", rd_q, sb_e.rd);
                        check_eq("sb_alu_ctrl", alu_ctrl_q, sb_e.alu_ctrl);
                        check_eq("sb_ctl", {alu_op_q, alusrc_q, branch_q, memread_q, memwrite_q,
                                            memtoreg_q, regwrite_q, ill_insn_q}, sb_e.ctl);
                    end
                end
            end
            if (in_valid && in_ready && !flush)
                sbq.push_back(model(instruction, pc_in, rdata1_in, rdata2_in, imm_in));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [63:0] pc);
        instruction = ins;
        pc_in       = pc;
        rdata1_in   = pc ^ 64'h5A5A_0000_0000_5A5A;
        rdata2_in   = {pc[31:0], ~pc[31:0]};
        imm_in      = pc + 64'd7;
        in_valid    = 1'b1;
    endtask

    localparam logic [31:0] ADD_X10  = 32'h00B5_0533;
    localparam logic [31:0] LW_X5    = 32'h0000_A283;
    localparam logic [31:0] ADD_X6   = 32'h0072_8333;
    localparam logic [31:0] ADDI_X8  = 32'h0053_0413;
    localparam logic [31:0] SW_X2    = 32'h0020_A423;
    localparam logic [31:0] BEQ      = 32'h0020_8063;
    localparam logic [31:0] ILLEGAL  = 32'h0000_057F;

    logic [31:0] stream [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, elapsed=%0t limit=100000", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instruction = '0; pc_in = '0; rdata1_in = '0; rdata2_in = '0; imm_in = '0;
        stream[0] = SW_X2; stream[1] = BEQ; stream[2] = ILLEGAL; stream[3] = ADD_X10; stream[4] = LW_X5;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pc_q", pc_q, 0);
        check_eq("rst_regwrite_q", regwrite_q, 0);
        check_eq("rst_rd_q", rd_q, 0);
        check_eq("rst_in_ready", in_ready, 1);
        tick(); tick();
        rst_n = 1'b1;

        // add x10,x10,x11
        present(ADD_X10, 64'h1000);
        #1 check_eq("add_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("add_out_valid", out_valid, 1);
        check_eq("add_rd_q", rd_q, 10);
        check_eq("add_rs2_q", rs2_q, 11);
        check_eq("add_regwrite_q", regwrite_q, 1);
        check_eq("add_alu_op_q", alu_op_q, 2'b10);
        tick();
        check_eq("drain_out_valid", out_valid, 0);
        check_eq("drain_regwrite_q", regwrite_q, 0);

        // Load-use: lw x5 then add x6,x5,x7
        present(LW_X5, 64'h2000);
        tick();
        present(ADD_X6, 64'h2004);
        #1;
        check_eq("lu_hazard", hazard_stall, 1);
        check_eq("lu_in_ready", in_ready, 0);
        tick();
        check_eq("lu_bubble_valid", out_valid, 0);
        check_eq("lu_bubble_memread", memread_q, 0);
        check_eq("lu_hazard_clear", hazard_stall, 0);
        check_eq("lu_in_ready_back", in_ready, 1);
        tick();
        check_eq("lu_add_valid", out_valid, 1);
        check_eq("lu_add_rd", rd_q, 6);
`ifdef ID_EX_PERF_EN
        check_eq("stall_cnt", stall_cnt, 1);
        check_eq("bubble_cnt", bubble_cnt, 2);
`endif

        // Hold for 3 cycles with addi queued behind
        out_ready = 1'b0;
        present(ADDI_X8, 64'h2008);
        #1 check_eq("hold_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_pc", pc_q, 64'h2004);
            check_eq("hold_instr", instr_q, ADD_X6);
            check_eq("hold_rd", rd_q, 6);
            check_eq("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 check_eq("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("release_valid", out_valid, 1);
        check_eq("release_rd", rd_q, 8);
        check_eq("release_pc", pc_q, 64'h2008);

        // Flush with entry held and input offered
        present(SW_X2, 64'h200C);
        flush = 1'b1;
        #1 check_eq("flush_in_ready", in_ready, 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_regwrite", regwrite_q, 0);
        tick();
        check_eq("flush_dropped", out_valid, 0);

        // Back-to-back stream, no bubbles expected
        for (int i = 0; i < 5; i++) begin
            present(stream[i], 64'h4000 + 64'(4 * i));
            tick();
            check_eq("stream_valid", out_valid, 1);
            if (stream[i][6:0] == 7'h7F) begin
                check_eq("ill_insn_q", ill_insn_q, 1);
                check_eq("ill_regwrite", regwrite_q, 0);
                check_eq("ill_memwrite", memwrite_q, 0);
                check_eq("ill_rd", rd_q, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream_end_valid", out_valid, 0);

        // Asynchronous reset in the middle of a hold
        present(ADD_X10, 64'h3000);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_pc", pc_q, 0);
        check_eq("mid_rst_regwrite", regwrite_q, 0);
        check_eq("mid_rst_rd", rd_q, 0);
        check_eq("mid_rst_instr", instr_q, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        present(ADD_X10, 64'h3004);
        #1 check_eq("post_rst_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_pc", pc_q, 64'h3004);
        tick();
        tick();
        check_eq("sb_left", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
